// File: rtl/dot_i8_stream_if.sv
// dot_i8_stream_if: operand beat stream and result handshake bundle.
// o_dp widens by acc_bits when DOT_I8_STREAM_ACC_EN is defined.
interface dot_i8_stream_if #(
   parameter int bit_width = 8,
   parameter int k         = 32,
   parameter int lanes     = 4,
   parameter int acc_bits  = 4
);
`ifdef DOT_I8_STREAM_ACC_EN
   localparam int out_width = 2*bit_width + $clog2(k) + acc_bits;
`else
   localparam int out_width = 2*bit_width + $clog2(k);
   localparam int unused_acc_bits = acc_bits;
`endif

   logic                             i_valid;
   logic                             o_ready;
   logic [lanes-1:0][bit_width-1:0]  i_a;
   logic [lanes-1:0][bit_width-1:0]  i_b;
   logic                             i_last;
   logic                             o_valid;
   logic                             i_ready;
   logic signed [out_width-1:0]      o_dp;

   modport master (
      output i_valid, i_a, i_b, i_last, i_ready,
      input  o_ready, o_valid, o_dp
   );

   modport slave (
      input  i_valid, i_a, i_b, i_last, i_ready,
      output o_ready, o_valid, o_dp
   );
endinterface

// File: rtl/dot_i8_stream.sv
// dot_i8_stream: beat-serial operand assembly around a dot_i8 core.
// Define DOT_I8_STREAM_ACC_EN to sum vectors into groups closed by i_last.
module dot_i8 #(
   parameter  int bit_width = 8,
   parameter  int k         = 32,
   localparam int dw        = 2*bit_width + $clog2(k)
) (
   input  logic [k-1:0][bit_width-1:0] a,
   input  logic [k-1:0][bit_width-1:0] b,
   output logic signed [dw-1:0]        dp
);
   localparam int pw = 2*bit_width;

   logic signed [pw-1:0] ax, bx, p;

   always_comb begin
      dp = '0;
      ax = '0;
      bx = '0;
      p  = '0;
      for (int i = 0; i < k; i++) begin
         ax = pw'(signed'(a[i]));
         bx = pw'(signed'(b[i]));
         p  = ax * bx;
         dp = dp + dw'(p);
      end
   end
endmodule

module dot_i8_stream #(
   parameter int bit_width = 8,
   parameter int k         = 32,
   parameter int lanes     = 4,
   parameter int acc_bits  = 4
) (
   input logic            clk,
   input logic            rst,
   dot_i8_stream_if.slave bus
);
   localparam int dw = 2*bit_width + $clog2(k);
`ifdef DOT_I8_STREAM_ACC_EN
   localparam int out_width = dw + acc_bits;
`else
   localparam int out_width = dw;
   localparam int unused_acc_bits = acc_bits;
`endif
   localparam int beats = k / lanes;
   localparam int bcw   = (beats > 1) ? $clog2(beats) : 1;

   typedef enum logic [1:0] {FILL, CALC, HOLD} state_t;

   state_t                        state_q, state_d;
   logic [bcw-1:0]                beat_q, beat_d;
   logic [k-1:0][bit_width-1:0]   a_q, a_d, b_q, b_d;
   logic                          o_valid_q, o_valid_d;
   logic                          o_ready_q, o_ready_d;
   logic signed [out_width-1:0]   o_dp_q, o_dp_d;
   logic signed [dw-1:0]          dot;
   logic signed [out_width-1:0]   dot_x;

`ifdef DOT_I8_STREAM_ACC_EN
   logic signed [out_width-1:0]   acc_q, acc_d;
   logic                          last_q, last_d;
   logic signed [out_width-1:0]   sum;

   assign sum = acc_q + dot_x;
`else
   logic unused_last;

   assign unused_last = bus.i_last;
`endif

   dot_i8 #(
      .bit_width (bit_width),
      .k         (k)
   ) u_dot (
      .a  (a_q),
      .b  (b_q),
      .dp (dot)
   );

   assign dot_x = out_width'(dot);

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      a_d       = a_q;
      b_d       = b_q;
      o_valid_d = o_valid_q;
      o_ready_d = o_ready_q;
      o_dp_d    = o_dp_q;
`ifdef DOT_I8_STREAM_ACC_EN
      acc_d     = acc_q;
      last_d    = last_q;
`endif
      unique case (state_q)
         FILL: begin
            if (bus.i_valid && o_ready_q) begin
               for (int j = 0; j < beats; j++) begin
                  if (beat_q == bcw'(j)) begin
                     a_d[j*lanes +: lanes] = bus.i_a;
                     b_d[j*lanes +: lanes] = bus.i_b;
                  end
               end
               if (beat_q == bcw'(beats-1)) begin
                  beat_d    = '0;
                  o_ready_d = 1'b0;
                  state_d   = CALC;
`ifdef DOT_I8_STREAM_ACC_EN
                  last_d    = bus.i_last;
`endif
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         CALC: begin
`ifdef DOT_I8_STREAM_ACC_EN
            if (last_q) begin
               o_dp_d    = sum;
               acc_d     = '0;
               o_valid_d = 1'b1;
               state_d   = HOLD;
            end else begin
               // Intermediate group vector: fold in and keep filling.
               acc_d     = sum;
               o_ready_d = 1'b1;
               state_d   = FILL;
            end
`else
            o_dp_d    = dot_x;
            o_valid_d = 1'b1;
            state_d   = HOLD;
`endif
         end
         HOLD: begin
            if (bus.i_ready) begin
               o_valid_d = 1'b0;
               o_ready_d = 1'b1;
               state_d   = FILL;
            end
         end
         default: begin
            state_d   = FILL;
            beat_d    = '0;
            o_valid_d = 1'b0;
            o_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         beat_q    <= '0;
         o_valid_q <= 1'b0;
         o_ready_q <= 1'b1;
         o_dp_q    <= '0;
`ifdef DOT_I8_STREAM_ACC_EN
         acc_q     <= '0;
         last_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         o_valid_q <= o_valid_d;
         o_ready_q <= o_ready_d;
         o_dp_q    <= o_dp_d;
`ifdef DOT_I8_STREAM_ACC_EN
         acc_q     <= acc_d;
         last_q    <= last_d;
`endif
      end
   end

   // Operands are fully rewritten before every CALC, so no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign bus.o_valid = o_valid_q;
   assign bus.o_ready = o_ready_q;
   assign bus.o_dp    = o_dp_q;
endmodule
